// File: rtl/btn_db_core.sv
// btn_db_core: MMIO push-button debouncer with press capture, press counter and maskable irq
module btn_db_core #(
  parameter int N_BTN  = 3,
  parameter int DB_CNT = 1_250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             read,
  input  logic             write,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [N_BTN-1:0] btn,
  output logic             irq
);
  localparam int CW = $clog2(DB_CNT);
  logic [N_BTN-1:0] s1, s2, stable, prev, capture, mask, rise;
  logic [CW-1:0]    cnt [N_BTN];
  logic [15:0]      press_cnt, pc;
  logic             sel, we, unused;
  assign sel    = addr[4:2] == 3'b0;
  assign we     = cs && write && sel;
  assign rise   = stable & ~prev;
  assign irq    = |(capture & mask);
  assign unused = ^{read, wr_data};
  always_comb begin
    pc = '0;
    for (int i = 0; i < N_BTN; i++) pc = pc + 16'(rise[i]);
  end
  always_comb
    rd_data = !sel ? '0 :
              addr[1:0] == 2'd0 ? 32'(stable) :
              addr[1:0] == 2'd1 ? 32'(capture) :
              addr[1:0] == 2'd2 ? 32'(mask) : {16'h0, press_cnt};
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      prev      <= '0;
      capture   <= '0;
      mask      <= '0;
      press_cnt <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= stable;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DB_CNT - 1)) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
      end
      capture   <= (capture & ~((we && addr[1:0] == 2'd1) ? wr_data[N_BTN-1:0] : '0)) | rise;
      mask      <= (we && addr[1:0] == 2'd2) ? wr_data[N_BTN-1:0] : mask;
      press_cnt <= ((we && addr[1:0] == 2'd3) ? 16'h0 : press_cnt) + pc;
    end
  end
endmodule

// File: tb/tb_btn_db_core.sv
// tb_btn_db_core: directed and randomized checks of btn_db_core against a behavioural model
module tb_btn_db_core;
  localparam int DB = 4;
  logic        clk, rst, cs, read, write, irq;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [2:0]  btn;
  int          n_cmp, n_bad;
  logic        chk_on;
  logic [2:0]  m_s1, m_s2, m_stable, m_cap, m_mask, m_pend;
  logic [15:0] m_cnt;
  logic [DB-1:0] m_hist [3];
  logic        m_we;
  logic [2:0]  m_clr;
  btn_db_core #(.N_BTN(3), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .btn(btn), .irq(irq)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a[4:2] != 0) return 0;
    return a[1:0] == 0 ? {29'b0, m_stable} : a[1:0] == 1 ? {29'b0, m_cap} :
           a[1:0] == 2 ? {29'b0, m_mask} : {16'b0, m_cnt};
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_cap = 0; m_mask = 0; m_pend = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
    end else begin
      m_we  = cs && write && addr[4:2] == 0;
      m_clr = (m_we && addr[1:0] == 1) ? wr_data[2:0] : 3'b0;
      m_cap = (m_cap & ~m_clr) | m_pend;
      m_cnt = ((m_we && addr[1:0] == 3) ? 16'h0 : m_cnt) + 16'($countones(m_pend));
      if (m_we && addr[1:0] == 2) m_mask = wr_data[2:0];
      m_pend = 0;
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
        if (m_hist[i] == {DB{~m_stable[i]}}) begin
          m_stable[i] = ~m_stable[i];
          m_pend[i]   = m_stable[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("model rd_data", rd_data, exp_rd(addr));
    chk("model irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1; write = 1; addr = a; wr_data = d;
    tick();
    cs = 0; write = 0; wr_data = 0;
  endtask
  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rd_data, exp);
  endtask
  task automatic rd_irq(input string nm, input logic exp);
    #1;
    chk(nm, {31'b0, irq}, {31'b0, exp});
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 0;
    rst = 1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0; btn = 0;
    tick();
    chk_on = 1;
    tick(2);
    rst = 0;
    for (int a = 0; a < 4; a++) rd("reset rd", 5'(a), 0);
    rd_irq("reset irq", 0);
    btn = 3'b001;
    tick(5);
    rd("stable before edge 6", 0, 0);
    tick();
    rd("stable at edge 6", 0, 1);
    rd("capture at edge 6", 1, 0);
    tick();
    rd("capture at edge 7", 1, 1);
    rd("press_cnt first", 3, 1);
    btn = 0;
    tick(10);
    rd("fall no count", 3, 1);
    wr(1, 7); wr(3, 0);
    rd("capture cleared", 1, 0);
    rd("cnt cleared", 3, 0);
    for (int k = 0; k < 4; k++) begin
      btn = (k % 2 == 0) ? 3'b010 : 3'b000;
      tick(2);
    end
    btn = 3'b010;
    tick(12);
    rd("bounce capture", 1, 3'b010);
    rd("bounce cnt", 3, 1);
    btn = 3'b110;
    tick(3);
    btn = 3'b010;
    tick(10);
    rd("glitch stable", 0, 3'b010);
    rd("glitch capture", 1, 3'b010);
    rd("glitch cnt", 3, 1);
    btn = 0;
    tick(10);
    wr(1, 7); wr(3, 0);
    wr(2, 3'b100);
    btn = 3'b100;
    tick(7);
    rd_irq("irq on masked press", 1);
    wr(1, 3'b100);
    rd_irq("irq after w1c", 0);
    rd("capture after w1c", 1, 0);
    btn = 0;
    tick(10);
    btn = 3'b100;
    tick(6);
    wr(1, 3'b100);
    rd("set wins over w1c", 1, 3'b100);
    rd_irq("irq set wins", 1);
    rd("cnt two presses", 3, 2);
    btn = 0;
    tick(10);
    wr(3, 0);
    btn = 3'b011;
    tick(6);
    wr(3, 0);
    rd("clear with 2 rises", 3, 2);
    btn = 0;
    tick(10);
    btn = 3'b111;
    tick(7);
    rd("three rises", 3, 5);
    rd("three captures", 1, 3'b111);
    btn = 0;
    tick(10);
    btn = 3'b001;
    tick(3);
    rst = 1;
    tick(2);
    for (int a = 0; a < 4; a++) rd("mid-reset rd", 5'(a), 0);
    rd_irq("mid-reset irq", 0);
    rst = 0;
    tick(5);
    rd("post-reset stable early", 0, 0);
    tick();
    rd("post-reset stable", 0, 1);
    tick();
    rd("post-reset cnt", 3, 1);
    rd("post-reset capture", 1, 1);
    rd("upper addr read", 5'b00101, 0);
    wr(5'b00110, 7);
    rd("upper addr write ignored", 2, 0);
    cs = 0; write = 1; addr = 2; wr_data = 7;
    tick();
    write = 0;
    rd("cs=0 write ignored", 2, 0);
    wr(2, 3);
    rd("mask write", 2, 3);
    rd_irq("irq mask 011", 1);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      cs      = $urandom_range(0, 5) == 0;
      write   = $urandom_range(0, 1) == 1;
      read    = $urandom_range(0, 1) == 1;
      addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
      wr_data = $urandom;
      rst     = $urandom_range(0, 499) == 0;
      tick();
    end
    rst = 0; cs = 0; write = 0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
